cmul_pipe: RTL and testbench
============================

# cmul_pipe

Parametrised, fully pipelined complex multiplier with valid/ready handshaking on both sides, per-sample conjugate mode, and configurable output scaling with round-half-up and saturation. It accepts one complex pair per cycle and returns one complex product per cycle after a fixed, parameter-set latency. It is the general-purpose successor to the fixed 16-bit, fixed-depth multiplier and is used in front of accumulators and FFT butterflies that apply backpressure.

## Interface

Parameters:
- `W`, 16: signed input component width (≥2).
- `LAT`, 2: pipeline depth in register stages from input acceptance to output (≥1).
- `SHIFT`, 0: arithmetic right shift applied to the full-precision result (0 ≤ SHIFT ≤ 2W).
- `OW`, 2*W+1: signed output component width (1 ≤ OW ≤ 2W+1).

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input pair present.
- `in_ready`, out, 1: block can accept input this cycle.
- `in_conj`, in, 1: 1 selects a·conj(b); 0 selects a·b. Sampled with the data.
- `ar`, `ai`, in, W each: operand a, real and imaginary, signed.
- `br`, `bi`, in, W each: operand b, real and imaginary, signed.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `pr`, `pi`, out, OW each: product, real and imaginary, signed.
- `sat`, out, 1: 1 when either component of this result was saturated.

## Operation

- Transfer rule: input is accepted on a cycle with `in_valid && in_ready`; output is consumed on a cycle with `out_valid && out_ready`.
- Normal mode (`in_conj`=0):
  - pr_full = ar·br − ai·bi
  - pi_full = ar·bi + ai·br
- Conjugate mode (`in_conj`=1):
  - pr_full = ar·br + ai·bi
  - pi_full = ai·br − ar·bi
- Full-precision width:
  - Products are 2W-bit signed. Sums and differences are computed at 2W+1 bits signed, so there is no internal overflow, including for (−2^(W−1))² + (−2^(W−1))².
- Scaling:
  - If SHIFT>0, add 2^(SHIFT−1) to the result, then arithmetic-shift right by SHIFT (round half toward +∞).
  - If SHIFT=0, pass the result unchanged.
  - The rounding add is performed at 2W+2 bits.
- Saturation:
  - A scaled value above 2^(OW−1)−1 clamps to 2^(OW−1)−1.
  - A scaled value below −2^(OW−1) clamps to −2^(OW−1).
  - `sat` = OR of both components' clamp conditions.
  - With the default OW and SHIFT=0, saturation never occurs.
- Pipeline structure:
  - LAT stages, each holding a valid bit and data.
  - Stage contents and the choice of registers at which multiply, add, round and saturate are performed are implementation choice. Visible latency is exactly LAT.
- Flow control:
  - Global enable: `en = !out_valid || out_ready`.
  - When `en`=1, all stages shift forward one position. The first stage captures the input's valid bit (`in_valid && in_ready`) and data.
  - When `en`=0, all stages hold.
  - `in_ready = en`, combinational from `out_valid` and `out_ready`.
  - Bubbles are not compressed: an empty stage still takes a cycle to drain.
- `out_valid`, `pr`, `pi`, `sat` come directly from the last stage's registers.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing

- Reset: on a cycle with `rst`=1, at the next edge all stage valid bits and data registers are cleared.
  - After reset: `out_valid`=0, `pr`=0, `pi`=0, `sat`=0.
  - After reset `in_ready`=1, since `out_valid`=0.
  - Reset takes priority over enable and input.
- Reset mid-operation: every in-flight sample is discarded and no result for it ever appears. Input presented during the reset cycle is not accepted.
- Latency: with no stall, an input accepted at edge k produces `out_valid`=1 with its result visible after edge k+LAT.
- Throughput: one result per cycle while `out_ready`=1.
- Stall: each cycle with `out_valid && !out_ready` freezes the whole pipe and adds exactly one cycle of latency to every in-flight sample.
- Ordering and data: order is preserved. No sample is dropped or duplicated across any stall pattern.
- Simultaneous events:
  - Output consume and input accept in the same cycle are both allowed.
  - `in_valid`=0 with `en`=1 inserts a bubble.
- `in_conj` is per-sample, so mixed conj/non-conj streams are valid back to back.

## Test plan

- Basic, W=16, LAT=2, SHIFT=0, OW=33, `out_ready`=1:
  - Stimulus: a=(3,4), b=(5,−2), conj=0.
  - Required: pr=23, pi=14, `sat`=0, result appears exactly 2 cycles after acceptance.
  - Same operands with conj=1: pr=7, pi=26.
- Extreme operands:
  - Stimulus: ar=ai=br=bi=−32768, conj=0.
  - With OW=33: pr=0, pi=2147483648, `sat`=0.
  - With OW=32: pi=2147483647, `sat`=1.
- Rounding, SHIFT=15, OW=18:
  - a=(1,0), b=(16384,0) gives pr=1 (exact half rounds up).
  - a=(−1,0), b=(16384,0) gives pr=0.
  - a=(16384,0), b=(16384,0) gives pr=8192.
- Backpressure, LAT=3:
  - Stimulus: stream 10 consecutive samples with conj alternating; toggle `out_ready` in the pattern 1,0,0,1,0,1,…
  - Required: all 10 results appear in order with correct values.
  - `in_ready`=0 exactly on cycles where `out_valid`=1 and `out_ready`=0.
  - Outputs are stable across each stall.
- Reset mid-stream:
  - Stimulus: accept 3 samples, assert `rst` for 1 cycle before any output, then send 1 new sample.
  - Required: cycle after reset has `out_valid`=0 and `pr`=`pi`=0. Only the new sample's result ever appears, LAT cycles after its acceptance.
- Bubbles, LAT=4:
  - Stimulus: `in_valid` pattern 1,0,1,1,0.
  - Required: `out_valid` reproduces the pattern 1,0,1,1,0 delayed by exactly 4 cycles.

Source files
------------

// File: rtl/cmul_pipe.sv
// Pipelined complex multiplier with valid/ready flow control,
// per-sample conjugate, round-half-up scaling and output saturation.
module cmul_pipe #(
  parameter int W     = 16,
  parameter int LAT   = 2,
  parameter int SHIFT = 0,
  parameter int OW    = 2*W+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_conj,
  input  logic [W-1:0]  ar,
  input  logic [W-1:0]  ai,
  input  logic [W-1:0]  br,
  input  logic [W-1:0]  bi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] pr,
  output logic [OW-1:0] pi,
  output logic          sat
);

  localparam int PW = 2*W;
  localparam int SW = PW+1;
  localparam int RW = PW+2;
  localparam int NR = (LAT > 1) ? LAT-1 : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT-1 : 0;

  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) <<< RS) : RW'(0);
  localparam logic signed [RW-1:0] LIM =
    RW'(1) <<< (OW-1);
  localparam logic signed [RW-1:0] MAXV = LIM - RW'(1);
  localparam logic signed [RW-1:0] MINV = RW'(0) - LIM;

  logic en;
  logic take;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign take     = in_valid && en;

  logic signed [PW-1:0] xar, xai, xbr, xbi;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

  assign xar = {{W{ar[W-1]}}, ar};
  assign xai = {{W{ai[W-1]}}, ai};
  assign xbr = {{W{br[W-1]}}, br};
  assign xbi = {{W{bi[W-1]}}, bi};

  assign m_rr = xar * xbr;
  assign m_ii = xai * xbi;
  assign m_ri = xar * xbi;
  assign m_ir = xai * xbr;

  logic                 f_v;
  logic                 f_conj;
  logic signed [PW-1:0] f_rr, f_ii, f_ri, f_ir;

  // With LAT>1 the products get their own register stage.
  generate
    if (LAT > 1) begin : g_mul
      logic                 s_v;
      logic                 s_conj;
      logic signed [PW-1:0] s_rr, s_ii, s_ri, s_ir;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_v    <= 1'b0;
          s_conj <= 1'b0;
          s_rr   <= '0;
          s_ii   <= '0;
          s_ri   <= '0;
          s_ir   <= '0;
        end else if (en) begin
          s_v    <= take;
          s_conj <= in_conj;
          s_rr   <= m_rr;
          s_ii   <= m_ii;
          s_ri   <= m_ri;
          s_ir   <= m_ir;
        end
      end

      assign f_v    = s_v;
      assign f_conj = s_conj;
      assign f_rr   = s_rr;
      assign f_ii   = s_ii;
      assign f_ri   = s_ri;
      assign f_ir   = s_ir;
    end else begin : g_comb
      assign f_v    = take;
      assign f_conj = in_conj;
      assign f_rr   = m_rr;
      assign f_ii   = m_ii;
      assign f_ri   = m_ri;
      assign f_ir   = m_ir;
    end
  endgenerate

  logic signed [SW-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [SW-1:0] f_re, f_im;

  assign e_rr = {f_rr[PW-1], f_rr};
  assign e_ii = {f_ii[PW-1], f_ii};
  assign e_ri = {f_ri[PW-1], f_ri};
  assign e_ir = {f_ir[PW-1], f_ir};

  always_comb begin
    f_re = e_rr - e_ii;
    f_im = e_ri + e_ir;
    if (f_conj) begin
      f_re = e_rr + e_ii;
      f_im = e_ir - e_ri;
    end
  end

  // Returns {clamped, value}; rounding add is one bit wider than the sum.
  function automatic logic [OW:0] scale(
    input logic signed [SW-1:0] x
  );
    logic signed [RW-1:0] t;
    t = {x[SW-1], x};
    t = t + RND;
    t = t >>> SHIFT;
    if (t > MAXV)
      scale = {1'b1, MAXV[OW-1:0]};
    else if (t < MINV)
      scale = {1'b1, MINV[OW-1:0]};
    else
      scale = {1'b0, t[OW-1:0]};
  endfunction

  logic [OW:0] s_re, s_im;

  assign s_re = scale(f_re);
  assign s_im = scale(f_im);

  logic [NR-1:0] rv;
  logic [NR-1:0] rsat;
  logic [OW-1:0] rpr [NR];
  logic [OW-1:0] rpi [NR];

  always_ff @(posedge clk) begin
    if (rst) begin
      rv   <= '0;
      rsat <= '0;
      for (int i = 0; i < NR; i++) begin
        rpr[i] <= '0;
        rpi[i] <= '0;
      end
    end else if (en) begin
      rv[0]   <= f_v;
      rsat[0] <= s_re[OW] | s_im[OW];
      rpr[0]  <= s_re[OW-1:0];
      rpi[0]  <= s_im[OW-1:0];
      for (int i = 1; i < NR; i++) begin
        rv[i]   <= rv[i-1];
        rsat[i] <= rsat[i-1];
        rpr[i]  <= rpr[i-1];
        rpi[i]  <= rpi[i-1];
      end
    end
  end

  assign out_valid = rv[NR-1];
  assign sat       = rsat[NR-1];
  assign pr        = rpr[NR-1];
  assign pi        = rpi[NR-1];

endmodule

// File: tb/tb_cmul_pipe.sv
// Testbench for cmul_pipe: four parameterisations sharing one stimulus
// bus, checked against an integer reference model.
module tb_cmul_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_conj, out_ready;
  logic [15:0] ar, ai, br, bi;

  logic u0_ir, u0_ov, u0_sat;
  logic [32:0] u0_pr, u0_pi;
  logic u1_ir, u1_ov, u1_sat;
  logic [31:0] u1_pr, u1_pi;
  logic u2_ir, u2_ov, u2_sat;
  logic [17:0] u2_pr, u2_pi;
  logic u3_ir, u3_ov, u3_sat;
  logic [32:0] u3_pr, u3_pi;

  int checks = 0;
  int errors = 0;

  longint qr[$];
  longint qi[$];
  bit     qs[$];

  always #5 clk = ~clk;

  cmul_pipe #(.W(16), .LAT(2), .SHIFT(0), .OW(33)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u0_ir),
    .in_conj(in_conj), .ar(ar), .ai(ai), .br(br), .bi(bi),
    .out_valid(u0_ov), .out_ready(out_ready),
    .pr(u0_pr), .pi(u0_pi), .sat(u0_sat));

  cmul_pipe #(.W(16), .LAT(2), .SHIFT(0), .OW(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_ir),
    .in_conj(in_conj), .ar(ar), .ai(ai), .br(br), .bi(bi),
    .out_valid(u1_ov), .out_ready(out_ready),
    .pr(u1_pr), .pi(u1_pi), .sat(u1_sat));

  cmul_pipe #(.W(16), .LAT(3), .SHIFT(15), .OW(18)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u2_ir),
    .in_conj(in_conj), .ar(ar), .ai(ai), .br(br), .bi(bi),
    .out_valid(u2_ov), .out_ready(out_ready),
    .pr(u2_pr), .pi(u2_pi), .sat(u2_sat));

  cmul_pipe #(.W(16), .LAT(4), .SHIFT(0), .OW(33)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u3_ir),
    .in_conj(in_conj), .ar(ar), .ai(ai), .br(br), .bi(bi),
    .out_valid(u3_ov), .out_ready(out_ready),
    .pr(u3_pr), .pi(u3_pi), .sat(u3_sat));

  // Complex product from the arithmetic definition, then round and clamp.
  function automatic void model(
    input int xar, input int xai, input int xbr, input int xbi,
    input bit c, input int sh, input int ow,
    output longint rr, output longint ri, output bit s);
    longint a_r, a_i, b_r, b_i, lim;
    longint v[2];
    bit s0;
    a_r = xar; a_i = xai; b_r = xbr; b_i = xbi;
    s0 = 1'b0;
    if (c) begin
      v[0] = a_r*b_r + a_i*b_i;
      v[1] = a_i*b_r - a_r*b_i;
    end else begin
      v[0] = a_r*b_r - a_i*b_i;
      v[1] = a_r*b_i + a_i*b_r;
    end
    lim = longint'(1) <<< (ow-1);
    for (int k = 0; k < 2; k++) begin
      if (sh > 0)
        v[k] = (v[k] + (longint'(1) <<< (sh-1))) >>> sh;
      if (v[k] > lim-1) begin
        v[k] = lim-1; s0 = 1'b1;
      end else if (v[k] < -lim) begin
        v[k] = -lim; s0 = 1'b1;
      end
    end
    rr = v[0]; ri = v[1]; s = s0;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drive(input bit v, input bit c,
    input int xar, input int xai, input int xbr, input int xbi);
    in_valid = v; in_conj = c;
    ar = 16'(xar); ai = 16'(xai); br = 16'(xbr); bi = 16'(xbi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1, 1, 100, -5, 7, 9);
    repeat (2) @(negedge clk);
    checks++;
    if ({u0_ov, u1_ov, u2_ov, u3_ov} !== 4'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0000",
        {u0_ov, u1_ov, u2_ov, u3_ov});
    end
    checks++;
    if ({u0_ir, u1_ir, u2_ir, u3_ir} !== 4'hf) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1111",
        {u0_ir, u1_ir, u2_ir, u3_ir});
    end
    checks++;
    if (u0_pr !== 33'd0 || u0_pi !== 33'd0 || u0_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0_data: got %0d %0d %b want 0 0 0",
        u0_pr, u0_pi, u0_sat);
    end
    checks++;
    if (u2_pr !== 18'd0 || u2_pi !== 18'd0 || u2_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_u2_data: got %0d %0d %b want 0 0 0",
        u2_pr, u2_pi, u2_sat);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    drive(1, 0, 3, 4, 5, -2);
    @(negedge clk);
    drive(1, 1, 3, 4, 5, -2);
    checks++;
    if (u0_ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got out_valid=%b want 0", u0_ov);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (u0_ov !== 1'b1 || u0_pr !== 33'd23 || u0_pi !== 33'd14 ||
        u0_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_mul: got v=%b %0d %0d s=%b want 1 23 14 0",
        u0_ov, $signed(u0_pr), $signed(u0_pi), u0_sat);
    end
    @(negedge clk);
    checks++;
    if (u0_ov !== 1'b1 || u0_pr !== 33'd7 || u0_pi !== 33'd26 ||
        u0_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_conj: got v=%b %0d %0d s=%b want 1 7 26 0",
        u0_ov, $signed(u0_pr), $signed(u0_pi), u0_sat);
    end
    @(negedge clk);
    checks++;
    if (u0_ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_tail: got out_valid=%b want 0", u0_ov);
    end
  endtask

  task automatic test_extreme();
    do_reset();
    out_ready = 1'b1;
    drive(1, 0, -32768, -32768, -32768, -32768);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (u0_ov !== 1'b1 || u0_pr !== 33'd0 ||
        u0_pi !== 33'd2147483648 || u0_sat !== 1'b0) begin
      errors++;
      $display("FAIL extreme_ow33: got v=%b %0d %0d s=%b want 1 0 2147483648 0",
        u0_ov, $signed(u0_pr), $signed(u0_pi), u0_sat);
    end
    checks++;
    if (u1_ov !== 1'b1 || u1_pr !== 32'd0 ||
        u1_pi !== 32'h7fffffff || u1_sat !== 1'b1) begin
      errors++;
      $display("FAIL extreme_ow32: got v=%b %0d %0d s=%b want 1 0 2147483647 1",
        u1_ov, $signed(u1_pr), $signed(u1_pi), u1_sat);
    end
    @(negedge clk);
  endtask

  task automatic test_round();
    int ta[3];
    int ex[3];
    ta = '{1, -1, 16384};
    ex = '{1, 0, 8192};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, ta[i], 0, 16384, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (u2_ov !== 1'b1 || u2_pr !== 18'(ex[i]) ||
          u2_pi !== 18'd0 || u2_sat !== 1'b0) begin
        errors++;
        $display("FAIL round_%0d: got v=%b pr=%0d pi=%0d want 1 %0d 0",
          i, u2_ov, $signed(u2_pr), $signed(u2_pi), ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, cyc;
    bit prev_stall;
    logic [17:0] hpr, hpi;
    logic hsat;
    bit pat[6];
    int x0, x1, x2, x3;
    longint er, ei;
    bit es;
    pat = '{1, 0, 0, 1, 0, 1};
    sent = 0; got = 0; cyc = 0; prev_stall = 0;
    hpr = '0; hpi = '0; hsat = 1'b0;
    qr.delete(); qi.delete(); qs.delete();
    do_reset();
    while (got < 10 && cyc < 200) begin
      if (prev_stall) begin
        checks++;
        if (u2_ov !== 1'b1 || u2_pr !== hpr || u2_pi !== hpi ||
            u2_sat !== hsat) begin
          errors++;
          $display("FAIL bp_hold: got v=%b %0d %0d want 1 %0d %0d",
            u2_ov, $signed(u2_pr), $signed(u2_pi),
            $signed(hpr), $signed(hpi));
        end
      end
      out_ready = pat[cyc % 6];
      x0 = rnd16(); x1 = rnd16(); x2 = rnd16(); x3 = rnd16();
      if (sent < 10)
        drive(1, sent[0], x0, x1, x2, x3);
      else
        drive(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (u2_ir !== !(u2_ov && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready: got %b want %b",
          u2_ir, !(u2_ov && !out_ready));
      end
      if (in_valid && u2_ir) begin
        model(x0, x1, x2, x3, sent[0], 15, 18, er, ei, es);
        qr.push_back(er); qi.push_back(ei); qs.push_back(es);
        sent++;
      end
      if (u2_ov && out_ready) begin
        checks++;
        if (qr.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got unexpected result want none");
        end else begin
          er = qr.pop_front(); ei = qi.pop_front(); es = qs.pop_front();
          if (u2_pr !== 18'(er) || u2_pi !== 18'(ei) || u2_sat !== es) begin
            errors++;
            $display("FAIL bp_data%0d: got %0d %0d %b want %0d %0d %b",
              got, $signed(u2_pr), $signed(u2_pi), u2_sat, er, ei, es);
          end
        end
        got++;
      end
      prev_stall = u2_ov && !out_ready;
      hpr = u2_pr; hpi = u2_pi; hsat = u2_sat;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL bp_timeout: got %0d results want 10", got);
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int x0, x1, x2, x3;
    longint er, ei;
    bit es;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, i[0], rnd16(), rnd16(), rnd16(), rnd16());
      @(negedge clk);
    end
    rst = 1'b1;
    drive(1, 0, 7, 7, 7, 7);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (u3_ov !== 1'b0 || u3_pr !== 33'd0 || u3_pi !== 33'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b %0d %0d want 0 0 0",
        u3_ov, u3_pr, u3_pi);
    end
    x0 = rnd16(); x1 = rnd16(); x2 = rnd16(); x3 = rnd16();
    model(x0, x1, x2, x3, 1'b1, 0, 33, er, ei, es);
    drive(1, 1, x0, x1, x2, x3);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    for (int m = 1; m <= 10; m++) begin
      checks++;
      if (m == 4) begin
        if (u3_ov !== 1'b1 || u3_pr !== 33'(er) || u3_pi !== 33'(ei) ||
            u3_sat !== es) begin
          errors++;
          $display("FAIL rstmid_new: got v=%b %0d %0d want 1 %0d %0d",
            u3_ov, $signed(u3_pr), $signed(u3_pi), er, ei);
        end
      end else if (u3_ov !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stray: got out_valid=%b at +%0d want 0",
          u3_ov, m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bubbles();
    bit pat[5];
    bit ev;
    int x0, x1, x2, x3;
    longint er, ei;
    bit es;
    pat = '{1, 0, 1, 1, 0};
    qr.delete(); qi.delete(); qs.delete();
    do_reset();
    out_ready = 1'b1;
    for (int m = 0; m <= 12; m++) begin
      ev = (m >= 4 && m <= 8) ? pat[m-4] : 1'b0;
      checks++;
      if (u3_ov !== ev) begin
        errors++;
        $display("FAIL bubble_valid%0d: got %b want %b", m, u3_ov, ev);
      end
      if (u3_ov && ev && qr.size() > 0) begin
        er = qr.pop_front(); ei = qi.pop_front(); es = qs.pop_front();
        checks++;
        if (u3_pr !== 33'(er) || u3_pi !== 33'(ei) || u3_sat !== es) begin
          errors++;
          $display("FAIL bubble_data%0d: got %0d %0d want %0d %0d",
            m, $signed(u3_pr), $signed(u3_pi), er, ei);
        end
      end
      if (m < 5 && pat[m]) begin
        x0 = rnd16(); x1 = rnd16(); x2 = rnd16(); x3 = rnd16();
        model(x0, x1, x2, x3, m[0], 0, 33, er, ei, es);
        qr.push_back(er); qi.push_back(ei); qs.push_back(es);
        drive(1, m[0], x0, x1, x2, x3);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int x0, x1, x2, x3, got, cyc;
    bit c;
    longint er, ei;
    bit es;
    qr.delete(); qi.delete(); qs.delete();
    do_reset();
    got = 0;
    cyc = 0;
    while (cyc < 60 || (qr.size() > 0 && cyc < 120)) begin
      x0 = rnd16(); x1 = rnd16(); x2 = rnd16(); x3 = rnd16();
      c = 1'($urandom_range(0, 1));
      out_ready = (cyc >= 60) ? 1'b1 : ($urandom_range(0, 9) < 6);
      if (cyc < 60 && $urandom_range(0, 9) < 7)
        drive(1, c, x0, x1, x2, x3);
      else
        drive(0, 0, 0, 0, 0, 0);
      #1;
      if (in_valid && u0_ir) begin
        model(x0, x1, x2, x3, c, 0, 33, er, ei, es);
        qr.push_back(er); qi.push_back(ei); qs.push_back(es);
      end
      if (u0_ov && out_ready) begin
        checks++;
        if (qr.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got unexpected result want none");
        end else begin
          er = qr.pop_front(); ei = qi.pop_front(); es = qs.pop_front();
          if (u0_pr !== 33'(er) || u0_pi !== 33'(ei) || u0_sat !== es) begin
            errors++;
            $display("FAIL rand_data%0d: got %0d %0d %b want %0d %0d %b",
              got, $signed(u0_pr), $signed(u0_pi), u0_sat, er, ei, es);
          end
        end
        got++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (qr.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending want 0", qr.size());
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_extreme();
    test_round();
    test_backpressure();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
